// File: rtl/alu_dispatch.sv
// Registered instruction dispatcher: classifies one instruction into R/I/S/B/U/J/M/A/F,
// issues it to the selected unit, waits for completion (with timeout) and emits one writeback beat.
// Build option: ALU_DISPATCH_F_EXT_EN enables the F class and the rs3 operand.
module alu_dispatch #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned AW      = 5,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                iCLK,
    input  logic                iRST,
    input  logic                iIR_VALID,
    output logic                oIR_READY,
    input  logic [31:0]         iIR,
    output logic [AW-1:0]       oRS1,
    output logic [AW-1:0]       oRS2,
    output logic [AW-1:0]       oRS3,
    input  logic [XLEN-1:0]     iRS1_DATA,
    input  logic [XLEN-1:0]     iRS2_DATA,
    input  logic [XLEN-1:0]     iRS3_DATA,
    output logic [8:0]          oUNIT_VALID,
    output logic [31:0]         oUNIT_IR,
    output logic [XLEN-1:0]     oUNIT_IN1,
    output logic [XLEN-1:0]     oUNIT_IN2,
    output logic [XLEN-1:0]     oUNIT_IN3,
    input  logic [8:0]          iUNIT_DONE,
    input  logic [9*XLEN-1:0]   iUNIT_OUT,
    output logic                oWB_VALID,
    output logic                oWB_EN,
    output logic [AW-1:0]       oWB_RD,
    output logic [XLEN-1:0]     oWB_DATA,
    output logic                oERR
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_DISPATCH = 2'd1;
    localparam logic [1:0] S_WAIT     = 2'd2;
    localparam logic [1:0] S_WB       = 2'd3;

    localparam logic [8:0] CLS_R = 9'h001;
    localparam logic [8:0] CLS_I = 9'h002;
    localparam logic [8:0] CLS_S = 9'h004;
    localparam logic [8:0] CLS_B = 9'h008;
    localparam logic [8:0] CLS_U = 9'h010;
    localparam logic [8:0] CLS_J = 9'h020;
    localparam logic [8:0] CLS_M = 9'h040;
    localparam logic [8:0] CLS_A = 9'h080;
`ifdef ALU_DISPATCH_F_EXT_EN
    localparam logic [8:0] CLS_F    = 9'h100;
    localparam logic [8:0] CLS_MASK = 9'h1FF;
`else
    localparam logic [8:0] CLS_MASK = 9'h0FF;
`endif

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [8:0]      cls_q, cls_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] in1_q, in1_d, in2_q, in2_d, in3_q, in3_d;
    logic            ready_q, ready_d;
    logic [8:0]      unit_valid_q, unit_valid_d;
    logic            wb_valid_q, wb_valid_d;
    logic            wb_en_q, wb_en_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            err_q, err_d;

    logic [8:0]      cls_c;
    logic            rd_zero_c, rs1_zero_c, rs2_zero_c, rs3_use_c;
    logic [AW-1:0]   rd_c;
    logic            done_c;
    logic [XLEN-1:0] unit_res_c;

    // Opcode classification and which register fields the class actually uses
    always_comb begin
        cls_c      = '0;
        rd_zero_c  = 1'b0;
        rs1_zero_c = 1'b0;
        rs2_zero_c = 1'b0;
        rs3_use_c  = 1'b0;
        case (iIR[6:0])
            7'b0110011: cls_c = (iIR[31:25] == 7'b0000001) ? CLS_M : CLS_R;
            7'b0010011, 7'b0000011, 7'b1100111: begin
                cls_c      = CLS_I;
                rs2_zero_c = 1'b1;
            end
            7'b0100011: begin
                cls_c     = CLS_S;
                rd_zero_c = 1'b1;
            end
            7'b1100011: begin
                cls_c     = CLS_B;
                rd_zero_c = 1'b1;
            end
            7'b0110111, 7'b0010111: begin
                cls_c      = CLS_U;
                rs1_zero_c = 1'b1;
                rs2_zero_c = 1'b1;
            end
            7'b1101111: begin
                cls_c      = CLS_J;
                rs1_zero_c = 1'b1;
                rs2_zero_c = 1'b1;
            end
            7'b0101111: cls_c = CLS_A;
`ifdef ALU_DISPATCH_F_EXT_EN
            7'b0000111, 7'b1010011: cls_c = CLS_F;
            7'b0100111: begin
                cls_c     = CLS_F;
                rd_zero_c = 1'b1;
            end
            7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: begin
                cls_c     = CLS_F;
                rs3_use_c = 1'b1;
            end
`endif
            default: cls_c = '0;
        endcase
    end

    assign rd_c = rd_zero_c  ? '0 : AW'(iIR[11:7]);
    assign oRS1 = rs1_zero_c ? '0 : AW'(iIR[19:15]);
    assign oRS2 = rs2_zero_c ? '0 : AW'(iIR[24:20]);
    assign oRS3 = rs3_use_c  ? AW'(iIR[31:27]) : '0;

    // Completion and result of the selected unit only
    always_comb begin
        unit_res_c = '0;
        for (int k = 0; k < 9; k++) begin
            if (cls_q[k]) unit_res_c = unit_res_c | iUNIT_OUT[k*XLEN +: XLEN];
        end
    end
    assign done_c = |(iUNIT_DONE & cls_q & CLS_MASK);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cls_d        = cls_q;
        rd_d         = rd_q;
        ir_d         = ir_q;
        in1_d        = in1_q;
        in2_d        = in2_q;
        in3_d        = in3_q;
        ready_d      = ready_q;
        unit_valid_d = '0;
        wb_valid_d   = 1'b0;
        wb_en_d      = 1'b0;
        wb_data_d    = wb_data_q;
        err_d        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (iIR_VALID) begin
                    cls_d     = cls_c & CLS_MASK;
                    rd_d      = rd_c;
                    ir_d      = iIR;
                    in1_d     = (oRS1 != '0) ? iRS1_DATA : '0;
                    in2_d     = (oRS2 != '0) ? iRS2_DATA : '0;
                    in3_d     = (oRS3 != '0) ? iRS3_DATA : '0;
                    cnt_d     = '0;
                    wb_data_d = '0;
                    ready_d   = 1'b0;
                    if ((cls_c & CLS_MASK) != '0) begin
                        state_d      = S_DISPATCH;
                        unit_valid_d = cls_c & CLS_MASK;
                    end else begin
                        state_d    = S_WB;
                        wb_valid_d = 1'b1;
                        err_d      = 1'b1;
                    end
                end
            end
            S_DISPATCH, S_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                // Done has priority over a coincident timeout
                if (done_c) begin
                    state_d    = S_WB;
                    wb_valid_d = 1'b1;
                    wb_en_d    = (rd_q != '0);
                    wb_data_d  = unit_res_c;
                end else if (state_q == S_WAIT && cnt_q == CW'(TIMEOUT)) begin
                    state_d    = S_WB;
                    wb_valid_d = 1'b1;
                    wb_data_d  = '0;
                    err_d      = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            cls_q        <= '0;
            rd_q         <= '0;
            ir_q         <= '0;
            in1_q        <= '0;
            in2_q        <= '0;
            in3_q        <= '0;
            ready_q      <= 1'b1;
            unit_valid_q <= '0;
            wb_valid_q   <= 1'b0;
            wb_en_q      <= 1'b0;
            wb_data_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cls_q        <= cls_d;
            rd_q         <= rd_d;
            ir_q         <= ir_d;
            in1_q        <= in1_d;
            in2_q        <= in2_d;
            in3_q        <= in3_d;
            ready_q      <= ready_d;
            unit_valid_q <= unit_valid_d;
            wb_valid_q   <= wb_valid_d;
            wb_en_q      <= wb_en_d;
            wb_data_q    <= wb_data_d;
            err_q        <= err_d;
        end
    end

    assign oIR_READY   = ready_q;
    assign oUNIT_VALID = unit_valid_q;
    assign oUNIT_IR    = ir_q;
    assign oUNIT_IN1   = in1_q;
    assign oUNIT_IN2   = in2_q;
    assign oUNIT_IN3   = in3_q;
    assign oWB_VALID   = wb_valid_q;
    assign oWB_EN      = wb_en_q;
    assign oWB_RD      = rd_q;
    assign oWB_DATA    = wb_data_q;
    assign oERR        = err_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Randomized self-checking bench for alu_dispatch against a transaction-level reference model.
module tb_alu_dispatch;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned AW      = 5;
    localparam int unsigned TIMEOUT = 15;
`ifdef ALU_DISPATCH_F_EXT_EN
    localparam bit F_EN = 1'b1;
`else
    localparam bit F_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                ir_valid;
    logic                ir_ready;
    logic [31:0]         ir;
    logic [AW-1:0]       rs1, rs2, rs3;
    logic [XLEN-1:0]     rs1_data, rs2_data, rs3_data;
    logic [8:0]          unit_valid;
    logic [31:0]         unit_ir;
    logic [XLEN-1:0]     unit_in1, unit_in2, unit_in3;
    logic [8:0]          unit_done;
    logic [9*XLEN-1:0]   unit_out;
    logic                wb_valid, wb_en, err;
    logic [AW-1:0]       wb_rd;
    logic [XLEN-1:0]     wb_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_dispatch #(.XLEN(XLEN), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .iCLK(clk), .iRST(rst), .iIR_VALID(ir_valid), .oIR_READY(ir_ready), .iIR(ir),
        .oRS1(rs1), .oRS2(rs2), .oRS3(rs3),
        .iRS1_DATA(rs1_data), .iRS2_DATA(rs2_data), .iRS3_DATA(rs3_data),
        .oUNIT_VALID(unit_valid), .oUNIT_IR(unit_ir),
        .oUNIT_IN1(unit_in1), .oUNIT_IN2(unit_in2), .oUNIT_IN3(unit_in3),
        .iUNIT_DONE(unit_done), .iUNIT_OUT(unit_out),
        .oWB_VALID(wb_valid), .oWB_EN(wb_en), .oWB_RD(wb_rd), .oWB_DATA(wb_data), .oERR(err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Class index 0..8 = R,I,S,B,U,J,M,A,F; -1 = illegal
    function automatic int ref_class(input logic [31:0] w);
        logic [6:0] op = w[6:0];
        if (op == 7'b0110011) return (w[31:25] == 7'b0000001) ? 6 : 0;
        if (op inside {7'b0010011, 7'b0000011, 7'b1100111}) return 1;
        if (op == 7'b0100011) return 2;
        if (op == 7'b1100011) return 3;
        if (op inside {7'b0110111, 7'b0010111}) return 4;
        if (op == 7'b1101111) return 5;
        if (op == 7'b0101111) return 7;
        if (op inside {7'b0000111, 7'b0100111, 7'b1000011, 7'b1000111,
                       7'b1001011, 7'b1001111, 7'b1010011}) return F_EN ? 8 : -1;
        return -1;
    endfunction

    function automatic logic [4:0] ref_rd(input logic [31:0] w);
        int c = ref_class(w);
        if (c == 2 || c == 3 || w[6:0] == 7'b0100111) return 5'd0;
        return w[11:7];
    endfunction

    function automatic logic [4:0] ref_rs1(input logic [31:0] w);
        int c = ref_class(w);
        return (c == 4 || c == 5) ? 5'd0 : w[19:15];
    endfunction

    function automatic logic [4:0] ref_rs2(input logic [31:0] w);
        int c = ref_class(w);
        return (c == 1 || c == 4 || c == 5) ? 5'd0 : w[24:20];
    endfunction

    function automatic logic [4:0] ref_rs3(input logic [31:0] w);
        int c = ref_class(w);
        if (c == 8 && w[6:0] inside {7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111}) return w[31:27];
        return 5'd0;
    endfunction

    function automatic bit ref_writes(input logic [31:0] w);
        int c = ref_class(w);
        return (c inside {0, 1, 4, 5, 6, 7}) || (c == 8 && w[6:0] != 7'b0100111);
    endfunction

    // One instruction; done_at = cycle after accept (0 = DISPATCH) the unit reports done, >TIMEOUT = never
    task automatic run_txn(input logic [31:0] w, input logic [31:0] d1, input logic [31:0] d2,
                           input logic [31:0] d3, input logic [31:0] res, input int done_at,
                           input bit stray_en);
        int        c = ref_class(w);
        int        cyc = 0;
        int        guard = 0;
        bit        seen = 1'b0;
        bit        exp_err;
        int        exp_lat;
        logic [8:0] oh;
        logic [8:0] stray;
        while (!ir_ready && guard < 40) begin
            @(posedge clk); #1; guard++;
        end
        check_eq("ready_before", 32'(ir_ready), 32'd1);
        ir = w; rs1_data = d1; rs2_data = d2; rs3_data = d3; ir_valid = 1'b1;
        #1;
        if (c >= 0) begin
            check_eq("rs1", 32'(rs1), 32'(ref_rs1(w)));
            check_eq("rs2", 32'(rs2), 32'(ref_rs2(w)));
            check_eq("rs3", 32'(rs3), 32'(ref_rs3(w)));
        end
        @(posedge clk); #1;
        ir_valid = 1'b0; ir = $urandom(); rs1_data = $urandom(); rs2_data = $urandom(); rs3_data = $urandom();
        if (c < 0) begin
            check_eq("ill_wb_valid", 32'(wb_valid), 32'd1);
            check_eq("ill_err", 32'(err), 32'd1);
            check_eq("ill_en", 32'(wb_en), 32'd0);
            check_eq("ill_data", wb_data, 32'd0);
            check_eq("ill_unit_valid", 32'(unit_valid), 32'd0);
        end else begin
            oh = 9'd1 << c;
            exp_err = (done_at > int'(TIMEOUT));
            exp_lat = exp_err ? int'(TIMEOUT) + 1 : done_at + 1;
            check_eq("unit_valid", 32'(unit_valid), 32'(oh));
            check_eq("unit_ir", unit_ir, w);
            check_eq("unit_in1", unit_in1, (ref_rs1(w) != 0) ? d1 : 32'd0);
            check_eq("unit_in2", unit_in2, (ref_rs2(w) != 0) ? d2 : 32'd0);
            check_eq("unit_in3", unit_in3, (ref_rs3(w) != 0) ? d3 : 32'd0);
            while (!seen && cyc < int'(TIMEOUT) + 4) begin
                stray = stray_en ? ((9'($urandom()) | 9'h001) & ~oh) : 9'h000;
                unit_done = stray | ((cyc == done_at) ? oh : 9'h000);
                for (int k = 0; k < 9; k++) unit_out[k*XLEN +: XLEN] = $urandom();
                unit_out[c*XLEN +: XLEN] = res;
                @(posedge clk); #1;
                cyc++;
                unit_done = '0;
                if (wb_valid) seen = 1'b1;
                else if (cyc == 1) check_eq("unit_valid_drop", 32'(unit_valid), 32'd0);
            end
            check_eq("wb_seen", 32'(seen), 32'd1);
            check_eq("wb_latency", 32'(cyc), 32'(exp_lat));
            check_eq("wb_err", 32'(err), 32'(exp_err));
            check_eq("wb_data", wb_data, exp_err ? 32'd0 : res);
            check_eq("wb_en", 32'(wb_en), 32'(!exp_err && ref_rd(w) != 0 && ref_writes(w)));
            check_eq("wb_rd", 32'(wb_rd), 32'(ref_rd(w)));
            check_eq("unit_ir_hold", unit_ir, w);
        end
        @(posedge clk); #1;
        check_eq("ready_after", 32'(ir_ready), 32'd1);
        check_eq("wb_drop", 32'(wb_valid), 32'd0);
    endtask

    localparam logic [6:0] OP_TAB [17] = '{
        7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011,
        7'b0110111, 7'b0010111, 7'b1101111, 7'b0101111, 7'b0000111, 7'b0100111,
        7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111, 7'b1010011
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nwb;
        logic [31:0] w;
        int sel;
        int dat;
        rst = 1'b1; ir_valid = 1'b0; ir = '0;
        rs1_data = '0; rs2_data = '0; rs3_data = '0; unit_done = '0; unit_out = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", 32'(ir_ready), 32'd1);
        check_eq("rst_unit_valid", 32'(unit_valid), 32'd0);
        check_eq("rst_unit_ir", unit_ir, 32'd0);
        check_eq("rst_in1", unit_in1, 32'd0);
        check_eq("rst_wb_valid", 32'(wb_valid), 32'd0);
        check_eq("rst_wb_en", 32'(wb_en), 32'd0);
        check_eq("rst_wb_rd", 32'(wb_rd), 32'd0);
        check_eq("rst_wb_data", wb_data, 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_txn(32'h002081B3, 32'd5, 32'd7, 32'd0, 32'd12, 0, 1'b0);   // ADD x3,x1,x2
        run_txn(32'h022082B3, 32'd5, 32'd7, 32'd0, 32'd35, 4, 1'b1);   // MUL x5,x1,x2 with stray done
        run_txn(32'h0020A023, 32'd9, 32'd4, 32'd0, 32'h55, 0, 1'b0);   // SW x2,0(x1)
        run_txn(32'hFFFFFFFF, 32'd1, 32'd2, 32'd3, 32'd0, 0, 1'b0);    // illegal
        run_txn(32'h00508093, 32'd1, 32'd2, 32'd3, 32'hABCD, 99, 1'b1); // ADDI, timeout
        run_txn(32'h00508093, 32'd1, 32'd2, 32'd3, 32'hABCD, 15, 1'b1); // ADDI, done on 15th wait cycle
        run_txn(32'h00508093, 32'd1, 32'd2, 32'd3, 32'h1234, 14, 1'b0);
        run_txn(32'h18208543, 32'd1, 32'd2, 32'd3, 32'h7777, 2, 1'b1);  // FMADD

        // Reset while waiting drops the instruction
        ir = 32'h00508093; rs1_data = 32'd3; ir_valid = 1'b1;
        @(posedge clk); #1;
        ir_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("rstw_ready", 32'(ir_ready), 32'd1);
        check_eq("rstw_wb_valid", 32'(wb_valid), 32'd0);
        check_eq("rstw_unit_valid", 32'(unit_valid), 32'd0);
        check_eq("rstw_unit_ir", unit_ir, 32'd0);
        rst = 1'b0;
        nwb = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (wb_valid) nwb++;
        end
        check_eq("rstw_no_wb", 32'(nwb), 32'd0);

        for (int t = 0; t < 40; t++) begin
            w = $urandom();
            sel = $urandom_range(0, 17);
            w[6:0] = (sel == 17) ? 7'($urandom()) : OP_TAB[sel];
            if (w[6:0] == 7'b0110011 && $urandom_range(0, 1) == 1) w[31:25] = 7'b0000001;
            case ($urandom_range(0, 9))
                0:       dat = 0;
                6:       dat = 15;
                7:       dat = 14;
                8:       dat = 99;
                9:       dat = $urandom_range(7, 13);
                default: dat = $urandom_range(1, 6);
            endcase
            run_txn(w, $urandom(), $urandom(), $urandom(), $urandom(), dat, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
